pixel_tile_controller: RTL and testbench
========================================

Name: pixel_tile_controller

Overview:
Parametrised next-generation SRAM pixel mover for the edge-detector datapath. One transaction first writes a burst of processed 8-bit pixels back to SRAM, then fetches a 2-D tile of 24-bit RGB pixels with a programmable row pitch. Fetched pixels are converted to grayscale, or passed through raw, into a local window buffer for the filter core. It sits between the off-chip SRAM interface and the filter window logic.

Parameters:
ADDR_W, 16, SRAM address width.
PIX_W, 24, SRAM word width; RGB is 8:8:8 with R in bits [23:16].
GRAY_W, 8, output pixel width.
NUM_BUF, 20, window buffer depth; maximum pixels per phase.
SRAM_WAIT, 1, extra wait cycles per SRAM access; each access lasts SRAM_WAIT+1 cycles.

Ports:
clk  in  1  system clock
n_rst  in  1  reset; asynchronous, active-low
start  in  1  one-cycle request; sampled only in IDLE
gray_mode  in  1  1 = grayscale conversion, 0 = raw low byte
wr_base  in  ADDR_W  first write address
num_wr  in  $clog2(NUM_BUF+1)  pixels to write
data_in  in  NUM_BUF*GRAY_W  write pixels; element i is bits [i*GRAY_W +: GRAY_W]
rd_base  in  ADDR_W  tile origin address
num_rows  in  8  tile rows
num_cols  in  8  tile columns
pitch  in  ADDR_W  address step between rows
data_out  out  NUM_BUF*GRAY_W  window buffer; element i is the i-th fetched pixel in raster order
read_now  out  1  one-cycle pulse when data_out[rd_idx] has just been updated
rd_idx  out  $clog2(NUM_BUF)  index of the element just updated
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
err  out  1  set when the tile exceeds NUM_BUF; cleared by the next accepted start
address  out  ADDR_W  SRAM address
w_data  out  PIX_W  SRAM write data
r_data  in  PIX_W  SRAM read data
read_enable  out  1  SRAM read strobe
write_enable  out  1  SRAM write strobe

Behaviour:
- Reset (asynchronous, any state): state = IDLE; all outputs 0; data_out cleared; any access in flight is abandoned.
- IDLE: when start = 1, latch all inputs. num_wr is saturated to NUM_BUF. Tile total = num_rows*num_cols, computed 16 bits wide. If total > NUM_BUF, err = 1 and the read phase stops after NUM_BUF pixels.
- Next state after start: WR if num_wr > 0; else RD if total > 0; else DONE.
- WR: drive address = wr_base + k (mod 2^ADDR_W). w_data = {3{data_in[k]}}. Hold write_enable = 1 with address and data stable for SRAM_WAIT+1 cycles per pixel. Consecutive pixels run back-to-back with no gap. After the last pixel go to RD, or to DONE if total = 0.
- RD: pixel (r,c) is read from rd_base + r*pitch + c, mod 2^ADDR_W. Row-major order: c advances first, then r increments and c resets to 0. Address arithmetic uses a row-start accumulator; no multiplier.
- RD access timing: read_enable = 1 for SRAM_WAIT+1 cycles per pixel. r_data is sampled on the clock edge ending the last cycle of the access.
- RD buffer update: on that same edge, write data_out[n] and set read_now = 1, rd_idx = n for the following cycle.
- Conversion: in gray mode, Y = (R + 2G + B) >> 2, summed 10 bits wide then truncated to 8 bits. In raw mode, Y = r_data[7:0].
- Only elements 0..count-1 of data_out are written; all other elements keep their prior values.
- DONE: done = 1 for one cycle, then IDLE.
- busy = 1 in WR, RD and DONE.
- read_enable and write_enable are never high together. Both are 0 in IDLE and DONE. address and w_data read 0 whenever the corresponding enable is low.
- Latency: done is asserted exactly (num_wr' + total')*(SRAM_WAIT+1) + 1 cycles after the start edge, where num_wr' and total' are the saturated/clamped counts.
- start while busy is ignored.
- Input changes after start has been accepted have no effect on the transaction.

Test Plan:
1. Write burst: SRAM_WAIT=1, num_wr=3, data_in={E0,FE,E9}, wr_base=0, total=0 -> SRAM[0..2] = E0E0E0, FEFEFE, E9E9E9; write_enable high for exactly 6 cycles; done at cycle 7; read_enable never high.
2. Gray read: SRAM[5]=102030, 1x1 tile at rd_base=5, gray_mode=1 -> data_out[0]=0x20, read_now pulse with rd_idx=0. Repeat with gray_mode=0 -> data_out[0]=0x30.
3. Pitch and wrap: rows=2, cols=3, pitch=640, rd_base=FFFE -> read addresses in order FFFE, FFFF, 0000, 027E, 027F, 0280; six read_now pulses with rd_idx 0..5.
4. Overflow: rows=5, cols=5 -> exactly 20 reads; err=1; done 41 cycles after start.
5. Empty transaction: num_wr=0, rows=0 -> done one cycle after start; no enables asserted; err=0.
6. Reset mid-read: assert n_rst low during the 3rd read access -> read_enable, busy and data_out go to 0 immediately. A new start after reset completes normally.

Source files
------------

// File: rtl/pixel_tile_controller.sv
`default_nettype none
// ============================================================================
// Module   : pixel_tile_controller
// Brief    : SRAM pixel mover. Writes a burst of 8-bit pixels back to SRAM,
//            then fetches a 2-D RGB tile with a programmable row pitch and
//            stores grayscale or raw pixels in a local window buffer.
// Revision : 1.0  initial release
// ============================================================================
module pixel_tile_controller #(
    parameter int ADDR_W    = 16,
    parameter int PIX_W     = 24,
    parameter int GRAY_W    = 8,
    parameter int NUM_BUF   = 20,
    parameter int SRAM_WAIT = 1
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         start,
    input  logic                         gray_mode,
    input  logic [ADDR_W-1:0]            wr_base,
    input  logic [$clog2(NUM_BUF+1)-1:0] num_wr,
    input  logic [NUM_BUF*GRAY_W-1:0]    data_in,
    input  logic [ADDR_W-1:0]            rd_base,
    input  logic [7:0]                   num_rows,
    input  logic [7:0]                   num_cols,
    input  logic [ADDR_W-1:0]            pitch,
    output logic [NUM_BUF*GRAY_W-1:0]    data_out,
    output logic                         read_now,
    output logic [$clog2(NUM_BUF)-1:0]   rd_idx,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [ADDR_W-1:0]            address,
    output logic [PIX_W-1:0]             w_data,
    input  logic [PIX_W-1:0]             r_data,
    output logic                         read_enable,
    output logic                         write_enable
);

    localparam int c_CNT_W  = $clog2(NUM_BUF+1);
    localparam int c_IDX_W  = $clog2(NUM_BUF);
    localparam int c_WAIT_W = (SRAM_WAIT > 0) ? $clog2(SRAM_WAIT+1) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(SRAM_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_WAIT_W-1:0]   r_wait;
    logic [c_CNT_W-1:0]    r_k;
    logic [c_CNT_W-1:0]    r_n;
    logic [c_CNT_W-1:0]    r_wr_cnt;
    logic [c_CNT_W-1:0]    r_rd_cnt;
    logic [7:0]            r_col;
    logic [7:0]            r_cols;
    logic [ADDR_W-1:0]     r_wr_base;
    logic [ADDR_W-1:0]     r_rd_base;
    logic [ADDR_W-1:0]     r_pitch;
    logic [ADDR_W-1:0]     r_row_start;
    logic                  r_gray;
    logic [GRAY_W-1:0]     r_wbuf [NUM_BUF];
    logic [GRAY_W-1:0]     r_buf  [NUM_BUF];

    logic [15:0]           w_total;
    logic [c_CNT_W-1:0]    w_wr_cnt;
    logic [c_CNT_W-1:0]    w_rd_cnt;
    logic [c_CNT_W-1:0]    w_k_next;
    logic [c_CNT_W-1:0]    w_n_next;
    logic [7:0]            w_col_next;
    logic [GRAY_W+1:0]     w_sum;
    logic [GRAY_W-1:0]     w_pix;
    logic                  w_last;

    // Tile size, clamped counts and next-pixel indices
    assign w_total    = {8'd0, num_rows} * {8'd0, num_cols};
    assign w_wr_cnt   = (num_wr > c_CNT_W'(NUM_BUF)) ? c_CNT_W'(NUM_BUF) : num_wr;
    assign w_rd_cnt   = (w_total > 16'(NUM_BUF)) ? c_CNT_W'(NUM_BUF) : c_CNT_W'(w_total);
    assign w_k_next   = r_k + c_CNT_W'(1);
    assign w_n_next   = r_n + c_CNT_W'(1);
    assign w_col_next = r_col + 8'd1;
    assign w_last     = (r_wait == c_WAIT_LAST);

    // Luma approximation (R + 2G + B) / 4, carried two bits wide to avoid overflow
    assign w_sum = {2'b00, r_data[3*GRAY_W-1 -: GRAY_W]}
                 + {1'b0, r_data[2*GRAY_W-1 -: GRAY_W], 1'b0}
                 + {2'b00, r_data[GRAY_W-1:0]};
    assign w_pix = r_gray ? w_sum[GRAY_W+1:2] : r_data[GRAY_W-1:0];

    // Flatten the window buffer onto the output bus
    for (genvar g = 0; g < NUM_BUF; g++) begin : g_dout
        assign data_out[g*GRAY_W +: GRAY_W] = r_buf[g];
    end

    // Transaction sequencer: all SRAM strobes and status outputs are registered
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_wait       <= '0;
            r_k          <= '0;
            r_n          <= '0;
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_col        <= '0;
            r_cols       <= '0;
            r_wr_base    <= '0;
            r_rd_base    <= '0;
            r_pitch      <= '0;
            r_row_start  <= '0;
            r_gray       <= 1'b0;
            read_now     <= 1'b0;
            rd_idx       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            address      <= '0;
            w_data       <= '0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            for (int i = 0; i < NUM_BUF; i++) begin
                r_wbuf[i] <= '0;
                r_buf[i]  <= '0;
            end
        end else begin
            read_now <= 1'b0;
            done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_gray    <= gray_mode;
                        r_wr_base <= wr_base;
                        r_wr_cnt  <= w_wr_cnt;
                        r_rd_base <= rd_base;
                        r_cols    <= num_cols;
                        r_pitch   <= pitch;
                        r_rd_cnt  <= w_rd_cnt;
                        err       <= (w_total > 16'(NUM_BUF));
                        busy      <= 1'b1;
                        r_k       <= '0;
                        r_wait    <= '0;
                        for (int i = 0; i < NUM_BUF; i++) begin
                            r_wbuf[i] <= data_in[i*GRAY_W +: GRAY_W];
                        end
                        if (w_wr_cnt != '0) begin
                            r_state      <= S_WR;
                            write_enable <= 1'b1;
                            address      <= wr_base;
                            w_data       <= {3{data_in[GRAY_W-1:0]}};
                        end else if (w_rd_cnt != '0) begin
                            r_state     <= S_RD;
                            read_enable <= 1'b1;
                            address     <= rd_base;
                            r_row_start <= rd_base;
                            r_col       <= '0;
                            r_n         <= '0;
                        end else begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    if (w_last) begin
                        r_wait <= '0;
                        if (w_k_next < r_wr_cnt) begin
                            r_k     <= w_k_next;
                            address <= r_wr_base + ADDR_W'(w_k_next);
                            w_data  <= {3{r_wbuf[c_IDX_W'(w_k_next)]}};
                        end else begin
                            write_enable <= 1'b0;
                            w_data       <= '0;
                            if (r_rd_cnt != '0) begin
                                r_state     <= S_RD;
                                read_enable <= 1'b1;
                                address     <= r_rd_base;
                                r_row_start <= r_rd_base;
                                r_col       <= '0;
                                r_n         <= '0;
                            end else begin
                                r_state <= S_DONE;
                                address <= '0;
                                done    <= 1'b1;
                            end
                        end
                    end else begin
                        r_wait <= r_wait + c_WAIT_W'(1);
                    end
                end
                S_RD: begin
                    if (w_last) begin
                        r_wait                 <= '0;
                        r_buf[c_IDX_W'(r_n)]   <= w_pix;
                        read_now               <= 1'b1;
                        rd_idx                 <= c_IDX_W'(r_n);
                        if (w_n_next < r_rd_cnt) begin
                            r_n <= w_n_next;
                            if (w_col_next < r_cols) begin
                                r_col   <= w_col_next;
                                address <= r_row_start + ADDR_W'(w_col_next);
                            end else begin
                                r_col       <= '0;
                                r_row_start <= r_row_start + r_pitch;
                                address     <= r_row_start + r_pitch;
                            end
                        end else begin
                            r_state     <= S_DONE;
                            read_enable <= 1'b0;
                            address     <= '0;
                            done        <= 1'b1;
                        end
                    end else begin
                        r_wait <= r_wait + c_WAIT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_tile_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_tile_controller
// Brief    : Scoreboard bench for pixel_tile_controller with an SRAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pixel_tile_controller;

    localparam int ACC = 2;  // SRAM_WAIT + 1 cycles per access

    typedef struct packed {
        logic [15:0] lat;
        logic        err;
    } done_t;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic         gray_mode = 1'b0;
    logic [15:0]  wr_base = '0;
    logic [4:0]   num_wr = '0;
    logic [159:0] data_in = '0;
    logic [15:0]  rd_base = '0;
    logic [7:0]   num_rows = '0;
    logic [7:0]   num_cols = '0;
    logic [15:0]  pitch = '0;
    logic [159:0] data_out;
    logic         read_now;
    logic [4:0]   rd_idx;
    logic         busy, done, err;
    logic [15:0]  address;
    logic [23:0]  w_data;
    logic [23:0]  r_data;
    logic         read_enable, write_enable;

    logic [23:0]  mem [0:65535];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t_start = 0;
    int done_cnt = 0;
    int we_cyc = 0;
    int re_cyc = 0;
    int rd_acc_cnt = 0;

    logic [39:0] q_wr[$];
    logic [15:0] q_rd[$];
    logic [12:0] q_rn[$];
    done_t       q_done[$];

    pixel_tile_controller #(
        .ADDR_W(16), .PIX_W(24), .GRAY_W(8), .NUM_BUF(20), .SRAM_WAIT(1)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .gray_mode(gray_mode),
        .wr_base(wr_base), .num_wr(num_wr), .data_in(data_in),
        .rd_base(rd_base), .num_rows(num_rows), .num_cols(num_cols),
        .pitch(pitch), .data_out(data_out), .read_now(read_now),
        .rd_idx(rd_idx), .busy(busy), .done(done), .err(err),
        .address(address), .w_data(w_data), .r_data(r_data),
        .read_enable(read_enable), .write_enable(write_enable)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM read port: combinational data while the read strobe is high
    assign r_data = read_enable ? mem[address] : 24'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: SRAM model writes, bus invariants, and scoreboard pops
    task automatic monitor();
        int we_run = 0;
        int re_run = 0;
        logic [15:0] ha;
        logic [23:0] hd;
        logic [15:0] hr;
        logic [39:0] ew;
        logic [12:0] en;
        done_t       ed;
        forever begin
            @(negedge clk);
            chk("enable_exclusive", 32'(read_enable & write_enable), 32'd0);
            if (!write_enable) chk("wdata_idle", 32'(w_data), 32'd0);
            if (!read_enable && !write_enable) chk("addr_idle", 32'(address), 32'd0);
            if (write_enable) begin
                we_cyc++;
                mem[address] = w_data;
                if (we_run == 0) begin
                    chk("wr_expected", 32'(q_wr.size() > 0), 32'd1);
                    if (q_wr.size() > 0) begin
                        ew = q_wr.pop_front();
                        chk("wr_addr", 32'(address), 32'(ew[39:24]));
                        chk("wr_data", 32'(w_data), 32'(ew[23:0]));
                    end
                    ha = address;
                    hd = w_data;
                end else begin
                    chk("wr_addr_hold", 32'(address), 32'(ha));
                    chk("wr_data_hold", 32'(w_data), 32'(hd));
                end
                we_run = (we_run + 1) % ACC;
            end else begin
                we_run = 0;
            end
            if (read_enable) begin
                re_cyc++;
                if (re_run == 0) begin
                    rd_acc_cnt++;
                    chk("rd_expected", 32'(q_rd.size() > 0), 32'd1);
                    if (q_rd.size() > 0) chk("rd_addr", 32'(address), 32'(q_rd.pop_front()));
                    hr = address;
                end else begin
                    chk("rd_addr_hold", 32'(address), 32'(hr));
                end
                re_run = (re_run + 1) % ACC;
            end else begin
                re_run = 0;
            end
            if (read_now) begin
                chk("rn_expected", 32'(q_rn.size() > 0), 32'd1);
                if (q_rn.size() > 0) begin
                    en = q_rn.pop_front();
                    chk("rn_idx", 32'(rd_idx), 32'(en[12:8]));
                    chk("rn_pixel", 32'(data_out[int'(rd_idx)*8 +: 8]), 32'(en[7:0]));
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_expected", 32'(q_done.size() > 0), 32'd1);
                if (q_done.size() > 0) begin
                    ed = q_done.pop_front();
                    chk("done_latency", 32'(cyc - t_start), 32'(ed.lat));
                    chk("done_err", 32'(err), 32'(ed.err));
                    chk("done_busy", 32'(busy), 32'd1);
                end
            end
        end
    endtask

    task automatic txn(input logic g, input logic [15:0] wb, input logic [4:0] nw,
                       input logic [159:0] din, input logic [15:0] rb,
                       input logic [7:0] nr, input logic [7:0] nc, input logic [15:0] pt);
        @(negedge clk);
        gray_mode = g; wr_base = wb; num_wr = nw; data_in = din;
        rd_base = rb; num_rows = nr; num_cols = nc; pitch = pt;
        start = 1'b1;
        t_start = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble inputs; the accepted transaction must not notice
        gray_mode = ~g; wr_base = 16'hDEAD; num_wr = 5'd7; data_in = {5{32'hA5A5_5A5A}};
        rd_base = 16'h1234; num_rows = 8'd9; num_cols = 8'd9; pitch = 16'h0101;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_seen", 32'(done_cnt != d0), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("queues_drained", 32'(q_wr.size() + q_rd.size() + q_rn.size() + q_done.size()), 32'd0);
    endtask

    initial begin
        logic [159:0] din;
        int d0, w0, r0, n;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_read_now", 32'(read_now), 32'd0);
        chk("rst_enables", 32'({read_enable, write_enable}), 32'd0);
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_dout_any", 32'(|data_out), 32'd0);
        n_rst = 1'b1;

        // 1: write burst of three pixels, no read phase
        din = '0;
        din[23:0] = 24'hE9FEE0;
        q_wr.push_back({16'h0000, 24'hE0E0E0});
        q_wr.push_back({16'h0001, 24'hFEFEFE});
        q_wr.push_back({16'h0002, 24'hE9E9E9});
        q_done.push_back('{lat: 16'd7, err: 1'b0});
        d0 = done_cnt; w0 = we_cyc; r0 = re_cyc;
        txn(1'b0, 16'h0000, 5'd3, din, 16'h0000, 8'd0, 8'd5, 16'd0);
        wait_done(d0);
        chk("t1_we_cycles", 32'(we_cyc - w0), 32'd6);
        chk("t1_re_cycles", 32'(re_cyc - r0), 32'd0);
        chk("t1_mem0", 32'(mem[0]), 32'hE0E0E0);
        chk("t1_mem1", 32'(mem[1]), 32'hFEFEFE);
        chk("t1_mem2", 32'(mem[2]), 32'hE9E9E9);

        // 2: single-pixel read, grayscale then raw
        mem[5] = 24'h102030;
        q_rd.push_back(16'h0005);
        q_rn.push_back({5'd0, 8'h20});
        q_done.push_back('{lat: 16'd3, err: 1'b0});
        d0 = done_cnt;
        txn(1'b1, 16'h0000, 5'd0, '0, 16'h0005, 8'd1, 8'd1, 16'd0);
        wait_done(d0);
        chk("t2_gray_dout0", 32'(data_out[7:0]), 32'h20);
        q_rd.push_back(16'h0005);
        q_rn.push_back({5'd0, 8'h30});
        q_done.push_back('{lat: 16'd3, err: 1'b0});
        d0 = done_cnt;
        txn(1'b0, 16'h0000, 5'd0, '0, 16'h0005, 8'd1, 8'd1, 16'd0);
        wait_done(d0);
        chk("t2_raw_dout0", 32'(data_out[7:0]), 32'h30);

        // 3: 2x3 tile with pitch 640 wrapping past the top of memory
        mem[16'hFFFE] = 24'h1111A0; mem[16'hFFFF] = 24'h2222A1; mem[16'h0000] = 24'h3333A2;
        mem[16'h027E] = 24'h4444A3; mem[16'h027F] = 24'h5555A4; mem[16'h0280] = 24'h6666A5;
        q_rd.push_back(16'hFFFE); q_rd.push_back(16'hFFFF); q_rd.push_back(16'h0000);
        q_rd.push_back(16'h027E); q_rd.push_back(16'h027F); q_rd.push_back(16'h0280);
        for (int i = 0; i < 6; i++) q_rn.push_back({5'(i), 8'(8'hA0 + i)});
        q_done.push_back('{lat: 16'd13, err: 1'b0});
        d0 = done_cnt;
        txn(1'b0, 16'h0000, 5'd0, '0, 16'hFFFE, 8'd2, 8'd3, 16'd640);
        wait_done(d0);

        // 4: 5x5 tile overflows the 20-entry window; a start mid-run is ignored
        for (int i = 0; i < 25; i++) mem[16'h0100 + i] = {16'hC3C3, 8'(8'h40 + i)};
        for (int i = 0; i < 20; i++) begin
            q_rd.push_back(16'(16'h0100 + i));
            q_rn.push_back({5'(i), 8'(8'h40 + i)});
        end
        q_done.push_back('{lat: 16'd41, err: 1'b1});
        d0 = done_cnt; r0 = re_cyc;
        txn(1'b0, 16'h0000, 5'd0, '0, 16'h0100, 8'd5, 8'd5, 16'd5);
        repeat (6) @(negedge clk);
        num_rows = 8'd1; num_cols = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0);
        chk("t4_re_cycles", 32'(re_cyc - r0), 32'd40);
        chk("t4_err_held", 32'(err), 32'd1);
        chk("t4_dout19", 32'(data_out[159:152]), 32'h53);

        // 5: empty transaction clears err and touches nothing
        q_done.push_back('{lat: 16'd1, err: 1'b0});
        d0 = done_cnt; w0 = we_cyc; r0 = re_cyc;
        txn(1'b0, 16'h0040, 5'd0, '0, 16'h0000, 8'd0, 8'd7, 16'd0);
        wait_done(d0);
        chk("t5_no_enables", 32'((we_cyc - w0) + (re_cyc - r0)), 32'd0);
        chk("t5_err_clear", 32'(err), 32'd0);
        chk("t5_dout19_kept", 32'(data_out[159:152]), 32'h53);

        // Small tile only rewrites element 0
        q_rd.push_back(16'h0005);
        q_rn.push_back({5'd0, 8'h20});
        q_done.push_back('{lat: 16'd3, err: 1'b0});
        d0 = done_cnt;
        txn(1'b1, 16'h0000, 5'd0, '0, 16'h0005, 8'd1, 8'd1, 16'd0);
        wait_done(d0);
        chk("retain_dout1", 32'(data_out[15:8]), 32'h41);

        // 6: reset during the third read access
        for (int i = 0; i < 4; i++) mem[16'h0010 + i] = {16'h0000, 8'(8'hB0 + i)};
        q_rd.push_back(16'h0010); q_rd.push_back(16'h0011); q_rd.push_back(16'h0012);
        q_rn.push_back({5'd0, 8'hB0}); q_rn.push_back({5'd1, 8'hB1});
        r0 = rd_acc_cnt;
        txn(1'b0, 16'h0000, 5'd0, '0, 16'h0010, 8'd1, 8'd4, 16'd0);
        n = 0;
        while (rd_acc_cnt < r0 + 3 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t6_third_access", 32'(rd_acc_cnt - r0), 32'd3);
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        chk("t6_rst_read_enable", 32'(read_enable), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_dout_any", 32'(|data_out), 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        chk("t6_queues_flushed", 32'(q_rd.size() + q_rn.size()), 32'd0);
        q_rd.push_back(16'h0005);
        q_rn.push_back({5'd0, 8'h20});
        q_done.push_back('{lat: 16'd3, err: 1'b0});
        d0 = done_cnt;
        txn(1'b1, 16'h0000, 5'd0, '0, 16'h0005, 8'd1, 8'd1, 16'd0);
        wait_done(d0);
        chk("t6_after_dout0", 32'(data_out[7:0]), 32'h20);
        chk("t6_after_dout1", 32'(data_out[15:8]), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
